// File: rtl/reg_if_arb_pkg.sv
// Shared definitions for the register-interface arbiter: FSM encoding,
// default bus widths and the read data returned on an aborted access.
package reg_if_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int unsigned REG_IF_AW = 21;
  localparam int unsigned REG_IF_DW = 16;

  localparam logic [REG_IF_DW-1:0] ERR_RDATA_DEF = 16'hFFFF;

endpackage

// File: rtl/reg_if_arbiter_if.sv
// Bus bundle for the arbiter: two requester ports and the shared
// register-file port. slave = arbiter view, master = environment view.
interface reg_if_arbiter_if #(
  parameter int unsigned AW = 21,
  parameter int unsigned DW = 16
);
  logic          m0_valid, m1_valid;
  logic          m0_we,    m1_we;
  logic [AW-1:0] m0_addr,  m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready;

  logic          s_valid;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ready;

  modport slave (
    input  m0_valid, m1_valid, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, s_rdata, s_ready,
    output m0_rdata, m1_rdata, m0_ready, m1_ready,
           s_valid, s_we, s_addr, s_wdata
  );

  modport master (
    output m0_valid, m1_valid, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, s_rdata, s_ready,
    input  m0_rdata, m1_rdata, m0_ready, m1_ready,
           s_valid, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/reg_if_rr_pick.sv
// Combinational 2-way round-robin select. On a tie the requester that
// did not win last time is chosen.
module reg_if_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_idx_o,
  output logic       gnt_any_o
);

  // Single request wins outright; a tie goes to the non-last grantee.
  always_comb begin
    gnt_any_o = |req_i;
    gnt_idx_o = (&req_i) ? ~last_grant_i : req_i[1];
  end

endmodule

// File: rtl/reg_if_arbiter.sv
// Two-requester arbiter for the 25 MHz register interface. Serializes
// accesses with round-robin grant, registers the downstream request and
// aborts accesses the register file never acknowledges.
module reg_if_arbiter
  import reg_if_arb_pkg::*;
#(
  parameter int unsigned   AW          = REG_IF_AW,
  parameter int unsigned   DW          = REG_IF_DW,
  parameter int unsigned   TIMEOUT_CYC = 255,
  parameter logic [DW-1:0] ERR_RDATA   = DW'(ERR_RDATA_DEF)
) (
  input  logic                   clk_25m,
  input  logic                   rst_n,
  reg_if_arbiter_if.slave        bus,
  output logic                   busy,
  output logic                   owner,
  output logic                   timeout_pulse,
  output logic [7:0]             timeout_cnt
);

  // Wait counter value seen on the final ISSUE edge before abort.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  arb_state_e    state_q, state_d;
  logic          s_valid_q, s_valid_d;
  logic          s_we_q, s_we_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic [7:0]    wait_q, wait_d;
  logic          owner_q, owner_d;       // doubles as last_grant
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          to_pulse_q, to_pulse_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic          busy_q, busy_d;

  logic          gnt_idx, gnt_any;
  logic [DW-1:0] rsp_data;
  logic          done;

  reg_if_rr_pick u_pick (
    .req_i        ({bus.m1_valid, bus.m0_valid}),
    .last_grant_i (owner_q),
    .gnt_idx_o    (gnt_idx),
    .gnt_any_o    (gnt_any)
  );

  // Next-state and datapath: grant in IDLE, wait/abort in ISSUE, pulse in RESP.
  always_comb begin
    state_d    = state_q;
    s_valid_d  = s_valid_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    wait_d     = wait_q;
    owner_d    = owner_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    to_pulse_d = 1'b0;
    to_cnt_d   = to_cnt_q;
    rsp_data   = bus.s_rdata;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          s_valid_d = 1'b1;
          s_we_d    = gnt_idx ? bus.m1_we    : bus.m0_we;
          s_addr_d  = gnt_idx ? bus.m1_addr  : bus.m0_addr;
          s_wdata_d = gnt_idx ? bus.m1_wdata : bus.m0_wdata;
          owner_d   = gnt_idx;
          wait_d    = 8'd0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // An acknowledge on the expiry edge still counts as a normal completion.
        if (bus.s_ready) begin
          rsp_data = bus.s_rdata;
          done     = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          rsp_data   = ERR_RDATA;
          to_pulse_d = 1'b1;
          to_cnt_d   = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
          done       = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
        if (done) begin
          s_valid_d = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = rsp_data;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = rsp_data;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the request immediately.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_valid_q  <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      wait_q     <= 8'd0;
      owner_q    <= 1'b1;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      to_pulse_q <= 1'b0;
      to_cnt_q   <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_valid_q  <= s_valid_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      wait_q     <= wait_d;
      owner_q    <= owner_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      to_pulse_q <= to_pulse_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.s_valid    = s_valid_q;
  assign bus.s_we       = s_we_q;
  assign bus.s_addr     = s_addr_q;
  assign bus.s_wdata    = s_wdata_q;
  assign bus.m0_ready   = m0_ready_q;
  assign bus.m1_ready   = m1_ready_q;
  assign bus.m0_rdata   = m0_rdata_q;
  assign bus.m1_rdata   = m1_rdata_q;
  assign busy           = busy_q;
  assign owner          = owner_q;
  assign timeout_pulse  = to_pulse_q;
  assign timeout_cnt    = to_cnt_q;

endmodule

// File: tb/tb_reg_if_arbiter.sv
// Directed bench for reg_if_arbiter with TIMEOUT_CYC = 8.
module tb_reg_if_arbiter;

  logic       clk_25m = 1'b0;
  logic       rst_n;
  logic       busy, owner, timeout_pulse;
  logic [7:0] timeout_cnt;
  int         checks = 0;
  int         errors = 0;

  reg_if_arbiter_if #(.AW(21), .DW(16)) bus_if ();

  reg_if_arbiter #(.AW(21), .DW(16), .TIMEOUT_CYC(8), .ERR_RDATA(16'hFFFF)) dut (
    .clk_25m       (clk_25m),
    .rst_n         (rst_n),
    .bus           (bus_if),
    .busy          (busy),
    .owner         (owner),
    .timeout_pulse (timeout_pulse),
    .timeout_cnt   (timeout_cnt)
  );

  always #20 clk_25m = ~clk_25m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.m0_valid = 0; bus_if.m1_valid = 0;
    bus_if.m0_we = 0;    bus_if.m1_we = 0;
    bus_if.m0_addr = '0; bus_if.m1_addr = '0;
    bus_if.m0_wdata = '0; bus_if.m1_wdata = '0;
    bus_if.s_rdata = '0; bus_if.s_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    step();
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_s_valid", bus_if.s_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_tcnt", timeout_cnt, 0);
    chk("rst_m0_ready", bus_if.m0_ready, 0);
    chk("rst_m0_rdata", bus_if.m0_rdata, 0);

    // Single read from m0, zero-wait register file.
    bus_if.m0_valid = 1; bus_if.m0_we = 0; bus_if.m0_addr = 21'h01_0002;
    step();
    chk("rd_s_valid", bus_if.s_valid, 1);
    chk("rd_s_addr", bus_if.s_addr, 21'h01_0002);
    chk("rd_s_we", bus_if.s_we, 0);
    chk("rd_owner", owner, 0);
    chk("rd_busy", busy, 1);
    bus_if.s_ready = 1; bus_if.s_rdata = 16'hA5A5;
    step();
    chk("rd_m0_ready", bus_if.m0_ready, 1);
    chk("rd_m0_rdata", bus_if.m0_rdata, 16'hA5A5);
    chk("rd_m1_ready", bus_if.m1_ready, 0);
    chk("rd_s_valid_drop", bus_if.s_valid, 0);
    bus_if.s_ready = 0; bus_if.m0_valid = 0;
    step();
    chk("rd_ready_1cyc", bus_if.m0_ready, 0);
    chk("rd_idle", busy, 0);

    // Tie after reset: m0 first, then m1.
    do_reset();
    bus_if.m0_valid = 1; bus_if.m0_we = 1; bus_if.m0_addr = 21'h1; bus_if.m0_wdata = 16'h1111;
    bus_if.m1_valid = 1; bus_if.m1_we = 1; bus_if.m1_addr = 21'h2; bus_if.m1_wdata = 16'h2222;
    step();
    chk("tie_owner0", owner, 0);
    chk("tie_wdata0", bus_if.s_wdata, 16'h1111);
    chk("tie_we0", bus_if.s_we, 1);
    bus_if.s_ready = 1;
    step();
    chk("tie_m0_ready", bus_if.m0_ready, 1);
    chk("tie_m1_ready0", bus_if.m1_ready, 0);
    bus_if.s_ready = 0; bus_if.m0_valid = 0;
    step();
    chk("tie_resp_ignores_m1", bus_if.s_valid, 0);
    step();
    chk("tie_owner1", owner, 1);
    chk("tie_wdata1", bus_if.s_wdata, 16'h2222);
    chk("tie_addr1", bus_if.s_addr, 21'h2);
    bus_if.s_ready = 1;
    step();
    chk("tie_m1_ready", bus_if.m1_ready, 1);
    chk("tie_m0_ready0", bus_if.m0_ready, 0);
    bus_if.s_ready = 0; bus_if.m1_valid = 0;
    step();

    // Both held: grants alternate m0, m1, m0, m1.
    bus_if.m0_valid = 1; bus_if.m1_valid = 1; bus_if.s_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus_if.s_rdata = 16'h3000 + 16'(i);
      step();
      chk("alt_owner", owner, 32'(i % 2));
      step();
      chk("alt_m0_ready", bus_if.m0_ready, 32'((i % 2) == 0));
      chk("alt_m1_ready", bus_if.m1_ready, 32'((i % 2) == 1));
      if (i % 2 == 0) chk("alt_m0_rdata", bus_if.m0_rdata, 16'h3000 + 16'(i));
      else            chk("alt_m1_rdata", bus_if.m1_rdata, 16'h3000 + 16'(i));
      if (i == 3) begin bus_if.m0_valid = 0; bus_if.m1_valid = 0; end
      step();
    end
    bus_if.s_ready = 0;

    // Timeout: s_valid high exactly 8 cycles; requester drops valid early.
    bus_if.m0_valid = 1; bus_if.m0_we = 0;
    step();
    bus_if.m0_valid = 0;
    n = 1;
    while (bus_if.s_valid === 1'b1 && n < 20) begin
      chk("to_no_pulse_early", timeout_pulse, 0);
      step();
      if (bus_if.s_valid === 1'b1) n++;
    end
    chk("to_svalid_cycles", n, 8);
    chk("to_pulse", timeout_pulse, 1);
    chk("to_m0_ready", bus_if.m0_ready, 1);
    chk("to_m0_rdata", bus_if.m0_rdata, 16'hFFFF);
    chk("to_cnt1", timeout_cnt, 1);
    step();
    chk("to_pulse_1cyc", timeout_pulse, 0);

    // 255 more aborts: counter saturates at 255.
    for (int i = 0; i < 255; i++) begin
      bus_if.m0_valid = 1;
      step();
      bus_if.m0_valid = 0;
      repeat (8) step();
      step();
    end
    chk("to_cnt_sat", timeout_cnt, 255);

    // Acknowledge on the expiry cycle wins.
    do_reset();
    bus_if.m0_valid = 1;
    step();
    bus_if.m0_valid = 0;
    repeat (7) step();
    chk("exp_still_issue", bus_if.s_valid, 1);
    bus_if.s_ready = 1; bus_if.s_rdata = 16'h5A5A;
    step();
    chk("exp_m0_ready", bus_if.m0_ready, 1);
    chk("exp_m0_rdata", bus_if.m0_rdata, 16'h5A5A);
    chk("exp_no_pulse", timeout_pulse, 0);
    chk("exp_cnt0", timeout_cnt, 0);
    bus_if.s_ready = 0;
    step();

    // Reset mid-ISSUE drops everything immediately.
    bus_if.m0_valid = 1;
    step();
    chk("mr_issue", bus_if.s_valid, 1);
    chk("mr_owner0", owner, 0);
    #5 rst_n = 0;
    #1;
    chk("mr_s_valid", bus_if.s_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_owner", owner, 1);
    chk("mr_ready", {bus_if.m0_ready, bus_if.m1_ready}, 0);
    bus_if.m0_valid = 0;
    step();
    rst_n = 1;
    step();
    chk("mr_no_ready", {bus_if.m0_ready, bus_if.m1_ready}, 0);
    bus_if.m1_valid = 1; bus_if.m1_we = 1; bus_if.m1_addr = 21'h3; bus_if.m1_wdata = 16'hBEEF;
    step();
    chk("mr_next_owner", owner, 1);
    chk("mr_next_wdata", bus_if.s_wdata, 16'hBEEF);
    bus_if.s_ready = 1;
    step();
    chk("mr_next_ready", bus_if.m1_ready, 1);
    bus_if.s_ready = 0; bus_if.m1_valid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
